// File: rtl/ucsbece154a_defines.sv
// Shared constants and types for the ID/EX pipeline register.
package ucsbece154a_defines;

    localparam int CTRL_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;
    localparam logic [4:0] X0_IDX = 5'd0;

    // Everything in the E stage except the parameter-width control bundle
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } e_regs_t;

endpackage

// File: rtl/ucsbece154a_idex_if.sv
// Signal bundle between the decode side and the execute side of the ID/EX register.
interface ucsbece154a_idex_if #(
    parameter int CTRL_W = ucsbece154a_defines::CTRL_W_DEF
);
    logic              valid_d;
    logic [4:0]        rs1_d;
    logic [4:0]        rs2_d;
    logic [4:0]        rd_d;
    logic [31:0]       rd1_d;
    logic [31:0]       rd2_d;
    logic [31:0]       imm_d;
    logic [31:0]       pc_d;
    logic [31:0]       pcplus4_d;
    logic [CTRL_W-1:0] ctrl_d;
    logic              valid_e;
    logic [4:0]        rs1_e;
    logic [4:0]        rs2_e;
    logic [4:0]        rd_e;
    logic [31:0]       rd1_e;
    logic [31:0]       rd2_e;
    logic [31:0]       imm_e;
    logic [31:0]       pc_e;
    logic [31:0]       pcplus4_e;
    logic [CTRL_W-1:0] ctrl_e;

    modport master (
        output valid_d, rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_d, pc_d, pcplus4_d, ctrl_d,
        input  valid_e, rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_e, pc_e, pcplus4_e, ctrl_e
    );

    modport slave (
        input  valid_d, rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_d, pc_d, pcplus4_d, ctrl_d,
        output valid_e, rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_e, pc_e, pcplus4_e, ctrl_e
    );
endinterface

// File: rtl/ucsbece154a_bypass.sv
// Operand select: x0 reads as zero, a matching non-x0 writeback wins over the stored value.
module ucsbece154a_bypass
    import ucsbece154a_defines::*;
(
    input  logic [4:0]  rs_i,
    input  logic [31:0] data_i,
    input  logic        we_w_i,
    input  logic [4:0]  rd_w_i,
    input  logic [31:0] result_w_i,
    output logic [31:0] data_o
);

    logic wb_hit;

    always_comb begin
        wb_hit = we_w_i && (rd_w_i != X0_IDX) && (rd_w_i == rs_i);
        data_o = data_i;
        if (rs_i == X0_IDX) begin
            data_o = '0;
        end else if (wb_hit) begin
            data_o = result_w_i;
        end
    end

endmodule

// File: rtl/ucsbece154a_idex.sv
// ID/EX pipeline register with writeback bypass, stall refresh, flush bubbles
// and saturating stall/bubble performance counters.
module ucsbece154a_idex
    import ucsbece154a_defines::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_d_i,
    input  logic [4:0]        rs1_d_i,
    input  logic [4:0]        rs2_d_i,
    input  logic [4:0]        rd_d_i,
    input  logic [31:0]       rd1_d_i,
    input  logic [31:0]       rd2_d_i,
    input  logic [31:0]       imm_d_i,
    input  logic [31:0]       pc_d_i,
    input  logic [31:0]       pcplus4_d_i,
    input  logic [CTRL_W-1:0] ctrl_d_i,
    input  logic              we_w_i,
    input  logic [4:0]        rd_w_i,
    input  logic [31:0]       result_w_i,
    output logic              valid_e_o,
    output logic [4:0]        rs1_e_o,
    output logic [4:0]        rs2_e_o,
    output logic [4:0]        rd_e_o,
    output logic [31:0]       rd1_e_o,
    output logic [31:0]       rd2_e_o,
    output logic [31:0]       imm_e_o,
    output logic [31:0]       pc_e_o,
    output logic [31:0]       pcplus4_e_o,
    output logic [CTRL_W-1:0] ctrl_e_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    e_regs_t           e_q, e_d;
    logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [4:0]        byp1_rs, byp2_rs;
    logic [31:0]       byp1_in, byp2_in, byp1_out, byp2_out;
    logic              load_bubble;

    // While stalled the same selectors refresh the held operands instead of the D-stage ones
    assign byp1_rs = stall_i ? e_q.rs1 : rs1_d_i;
    assign byp1_in = stall_i ? e_q.rd1 : rd1_d_i;
    assign byp2_rs = stall_i ? e_q.rs2 : rs2_d_i;
    assign byp2_in = stall_i ? e_q.rd2 : rd2_d_i;

    ucsbece154a_bypass u_byp1 (
        .rs_i(byp1_rs), .data_i(byp1_in), .we_w_i(we_w_i),
        .rd_w_i(rd_w_i), .result_w_i(result_w_i), .data_o(byp1_out)
    );

    ucsbece154a_bypass u_byp2 (
        .rs_i(byp2_rs), .data_i(byp2_in), .we_w_i(we_w_i),
        .rd_w_i(rd_w_i), .result_w_i(result_w_i), .data_o(byp2_out)
    );

    always_comb begin
        e_d          = e_q;
        ctrl_e_d     = ctrl_e_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        load_bubble  = flush_i || (!stall_i && !valid_d_i);

        if (load_bubble) begin
            e_d      = '0;
            ctrl_e_d = '0;
        end else if (stall_i) begin
            if (e_q.valid) begin
                e_d.rd1 = byp1_out;
                e_d.rd2 = byp2_out;
            end
        end else begin
            e_d.valid   = 1'b1;
            e_d.rs1     = rs1_d_i;
            e_d.rs2     = rs2_d_i;
            e_d.rd      = rd_d_i;
            e_d.rd1     = byp1_out;
            e_d.rd2     = byp2_out;
            e_d.imm     = imm_d_i;
            e_d.pc      = pc_d_i;
            e_d.pcplus4 = pcplus4_d_i;
            ctrl_e_d    = ctrl_d_i;
        end

        // Counters stick at all-ones rather than wrapping
        if (stall_i && !flush_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (load_bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q          <= '0;
            ctrl_e_q     <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            e_q          <= e_d;
            ctrl_e_q     <= ctrl_e_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign valid_e_o    = e_q.valid;
    assign rs1_e_o      = e_q.rs1;
    assign rs2_e_o      = e_q.rs2;
    assign rd_e_o       = e_q.rd;
    assign rd1_e_o      = e_q.rd1;
    assign rd2_e_o      = e_q.rd2;
    assign imm_e_o      = e_q.imm;
    assign pc_e_o       = e_q.pc;
    assign pcplus4_e_o  = e_q.pcplus4;
    assign ctrl_e_o     = ctrl_e_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_ucsbece154a_idex.sv
// Directed self-checking bench for the ID/EX register: bypass, x0, stall refresh,
// flush bubbles, reset mid-stall and counter saturation (counters narrowed to 4 bits).
module tb_ucsbece154a_idex;

    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic        we_w_i;
    logic [4:0]  rd_w_i;
    logic [31:0] result_w_i;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    int assert_cnt;
    int fail_cnt;

    ucsbece154a_idex_if #(.CTRL_W(CTRL_W)) bus ();

    ucsbece154a_idex #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .valid_d_i(bus.valid_d), .rs1_d_i(bus.rs1_d), .rs2_d_i(bus.rs2_d),
        .rd_d_i(bus.rd_d), .rd1_d_i(bus.rd1_d), .rd2_d_i(bus.rd2_d),
        .imm_d_i(bus.imm_d), .pc_d_i(bus.pc_d), .pcplus4_d_i(bus.pcplus4_d),
        .ctrl_d_i(bus.ctrl_d), .we_w_i(we_w_i), .rd_w_i(rd_w_i),
        .result_w_i(result_w_i),
        .valid_e_o(bus.valid_e), .rs1_e_o(bus.rs1_e), .rs2_e_o(bus.rs2_e),
        .rd_e_o(bus.rd_e), .rd1_e_o(bus.rd1_e), .rd2_e_o(bus.rd2_e),
        .imm_e_o(bus.imm_e), .pc_e_o(bus.pc_e), .pcplus4_e_o(bus.pcplus4_e),
        .ctrl_e_o(bus.ctrl_e), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [4:0] rs1, input logic [31:0] rd1,
                         input logic [4:0] rs2, input logic [31:0] rd2, input logic [4:0] rd,
                         input logic [15:0] ctrl);
        bus.valid_d   = v;
        bus.rs1_d     = rs1;
        bus.rd1_d     = rd1;
        bus.rs2_d     = rs2;
        bus.rd2_d     = rd2;
        bus.rd_d      = rd;
        bus.ctrl_d    = ctrl;
        bus.imm_d     = 32'h0000_0100 + 32'(rd);
        bus.pc_d      = 32'h0000_1000 + 32'(rd);
        bus.pcplus4_d = 32'h0000_1004 + 32'(rd);
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] res);
        we_w_i     = we;
        rd_w_i     = rd;
        result_w_i = res;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_valid"}, 32'(bus.valid_e), 32'h0);
        check_output({tag, "_rd"}, 32'(bus.rd_e), 32'h0);
        check_output({tag, "_rd1"}, bus.rd1_e, 32'h0);
        check_output({tag, "_pc"}, bus.pc_e, 32'h0);
        check_output({tag, "_ctrl"}, 32'(bus.ctrl_e), 32'h0);
        check_output({tag, "_scnt"}, 32'(stall_cnt_o), 32'h0);
        check_output({tag, "_bcnt"}, 32'(bubble_cnt_o), 32'h0);
    endtask

    initial begin
        assert_cnt = 0;
        fail_cnt   = 0;
        reset      = 1'b1;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        set_d(1'b1, 5'd5, 32'h11, 5'd6, 32'h22, 5'd3, 16'h1234);
        #1;
        check_all_zero("reset");

        // Release reset between edges; first edge afterwards loads
        #11;
        reset = 1'b0;
        step();
        check_output("load_rd1", bus.rd1_e, 32'h11);
        check_output("load_rd2", bus.rd2_e, 32'h22);
        check_output("load_valid", 32'(bus.valid_e), 32'h1);
        check_output("load_rd", 32'(bus.rd_e), 32'h3);
        check_output("load_ctrl", 32'(bus.ctrl_e), 32'h1234);
        check_output("load_pc4", bus.pcplus4_e, 32'h1007);

        set_wb(1'b1, 5'd5, 32'hAA);
        step();
        check_output("wb_byp_rd1", bus.rd1_e, 32'hAA);
        check_output("wb_nobyp_rd2", bus.rd2_e, 32'h22);

        set_d(1'b1, 5'd5, 32'h11, 5'd0, 32'h55, 5'd4, 16'h0042);
        set_wb(1'b1, 5'd0, 32'h77);
        step();
        check_output("x0_rd2", bus.rd2_e, 32'h0);
        check_output("x0_wb_rd1", bus.rd1_e, 32'h11);

        set_d(1'b1, 5'd7, 32'h1, 5'd8, 32'h2, 5'd9, 16'hBEEF);
        set_wb(1'b0, 5'd0, 32'h0);
        step();
        check_output("pre_stall_rd1", bus.rd1_e, 32'h1);

        // Stalled: new D inputs ignored, only the matching operand refreshes
        stall_i = 1'b1;
        set_d(1'b1, 5'd1, 32'hDEAD, 5'd2, 32'hBEEF, 5'd10, 16'h5555);
        set_wb(1'b1, 5'd7, 32'h99);
        step();
        check_output("stall_rd1", bus.rd1_e, 32'h99);
        check_output("stall_rd2", bus.rd2_e, 32'h2);
        check_output("stall_rs1", 32'(bus.rs1_e), 32'h7);
        check_output("stall_rd", 32'(bus.rd_e), 32'h9);
        check_output("stall_ctrl", 32'(bus.ctrl_e), 32'hBEEF);
        check_output("stall_pc", bus.pc_e, 32'h1009);
        check_output("stall_scnt", 32'(stall_cnt_o), 32'h1);
        check_output("stall_bcnt", 32'(bubble_cnt_o), 32'h0);

        flush_i = 1'b1;
        step();
        check_output("flush_valid", 32'(bus.valid_e), 32'h0);
        check_output("flush_ctrl", 32'(bus.ctrl_e), 32'h0);
        check_output("flush_rd", 32'(bus.rd_e), 32'h0);
        check_output("flush_rd1", bus.rd1_e, 32'h0);
        check_output("flush_bcnt", 32'(bubble_cnt_o), 32'h1);
        check_output("flush_scnt", 32'(stall_cnt_o), 32'h1);

        flush_i = 1'b0;
        stall_i = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        set_d(1'b0, 5'd1, 32'h5, 5'd2, 32'h6, 5'd11, 16'h7777);
        step();
        check_output("invalid_valid", 32'(bus.valid_e), 32'h0);
        check_output("invalid_ctrl", 32'(bus.ctrl_e), 32'h0);
        check_output("invalid_bcnt", 32'(bubble_cnt_o), 32'h2);

        // Stall on a bubble: no refresh even if the writeback matches rs 0
        stall_i = 1'b1;
        set_wb(1'b1, 5'd3, 32'h1234);
        step();
        check_output("bubble_stall_rd1", bus.rd1_e, 32'h0);
        check_output("bubble_stall_scnt", 32'(stall_cnt_o), 32'h2);

        stall_i = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        set_d(1'b1, 5'd7, 32'h33, 5'd8, 32'h44, 5'd12, 16'h00C3);
        step();
        stall_i = 1'b1;
        step();
        check_output("held_rd1", bus.rd1_e, 32'h33);
        check_output("held_scnt", 32'(stall_cnt_o), 32'h3);

        // Reset between edges while stalled
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        #2;
        reset   = 1'b0;
        stall_i = 1'b0;
        set_d(1'b1, 5'd4, 32'h44, 5'd6, 32'h66, 5'd13, 16'hABCD);
        step();
        check_output("postreset_rd1", bus.rd1_e, 32'h44);
        check_output("postreset_valid", 32'(bus.valid_e), 32'h1);
        check_output("postreset_ctrl", 32'(bus.ctrl_e), 32'hABCD);
        check_output("postreset_scnt", 32'(stall_cnt_o), 32'h0);

        // Saturation of both 4-bit counters
        stall_i = 1'b1;
        for (int i = 0; i < 18; i++) step();
        check_output("sat_scnt", 32'(stall_cnt_o), 32'hF);
        flush_i = 1'b1;
        for (int i = 0; i < 18; i++) step();
        check_output("sat_bcnt", 32'(bubble_cnt_o), 32'hF);
        check_output("flush_noscnt", 32'(stall_cnt_o), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/ucsbece154a_idex.md
UCSBECE154A_IDEX -- requirements
Module: ucsbece154a_idex

Interface
REQ-001 SHALL have parameter CTRL_W, default 16: width of the decoded control bundle.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall and bubble counters.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port stall_i, input, 1: hold the E-stage register contents.
REQ-006 SHALL have port flush_i, input, 1: load a bubble into the E stage.
REQ-007 SHALL have port valid_d_i, input, 1: D-stage instruction valid.
REQ-008 SHALL have ports rs1_d_i, rs2_d_i and rd_d_i, input, 5 each: D-stage register indices.
REQ-009 SHALL have ports rd1_d_i and rd2_d_i, input, 32 each: register-file read data.
REQ-010 SHALL have ports imm_d_i, pc_d_i and pcplus4_d_i, input, 32 each: D-stage immediate, PC and PC+4.
REQ-011 SHALL have port ctrl_d_i, input, CTRL_W: D-stage control bundle.
REQ-012 SHALL have ports we_w_i (input, 1), rd_w_i (input, 5) and result_w_i (input, 32): writeback port, identical to the register-file write port.
REQ-013 SHALL have outputs valid_e_o (1), rs1_e_o, rs2_e_o, rd_e_o (5 each), rd1_e_o, rd2_e_o, imm_e_o, pc_e_o, pcplus4_e_o (32 each) and ctrl_e_o (CTRL_W): registered E-stage copies.
REQ-014 SHALL have outputs stall_cnt_o and bubble_cnt_o, CNT_W each: performance counters.

Function
REQ-015 SHALL apply the following priority on each rising edge: flush_i, then stall_i, then load.
REQ-016 Load SHALL capture every D-stage input into its E-stage counterpart, with operands passed through the bypass of REQ-017 and REQ-018.
REQ-017 Bypassed rd1 SHALL be:
- 0 when rs1_d_i==0;
- otherwise result_w_i when we_w_i && rd_w_i!=0 && rd_w_i==rs1_d_i;
- otherwise rd1_d_i.
REQ-018 Bypassed rd2 SHALL follow the same rule as REQ-017, using rs2_d_i and rd2_d_i.
REQ-019 Flush SHALL clear every E-stage output register to 0, including valid_e_o, ctrl_e_o and rd_e_o; flush with stall asserted SHALL still produce a bubble.
REQ-020 Stall SHALL hold all E-stage registers, except as given in REQ-021.
REQ-021 While stalled with valid_e_o=1:
- rd1_e_o SHALL update to result_w_i when we_w_i && rd_w_i!=0 && rd_w_i==rs1_e_o;
- rd2_e_o SHALL update likewise against rs2_e_o.
REQ-022 Load with valid_d_i=0 SHALL behave as a flush.
REQ-023 A write to x0 (rd_w_i==0) SHALL never be bypassed.
REQ-024 Latency SHALL be exactly one cycle from D inputs to E outputs; outputs SHALL be purely registered.
REQ-025 stall_cnt_o SHALL increment by 1 on each edge where stall_i=1 and flush_i=0.
REQ-026 bubble_cnt_o SHALL increment by 1 on each edge that loads a bubble (REQ-019 or REQ-022).
REQ-027 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-028 While reset is asserted, all outputs, including both counters, SHALL be 0 immediately, independent of clk.
REQ-029 The first load SHALL occur on the first rising edge after reset deasserts.
REQ-030 Reset asserted mid-stall SHALL discard the held instruction; no stall state SHALL survive reset.

Structure
REQ-031 CTRL_W, the x0 index constant and the counter width default SHALL reside in the shared ucsbece154a_defines header.
REQ-032 Operand selection SHALL be a sub-module, ucsbece154a_bypass, instantiated twice for D-stage selection and reused for the stall refresh of REQ-021.

Verification
REQ-033 Load: rs1=5, rd1_d=0x11, no WB -> after one edge, rd1_e_o=0x11, valid_e_o=1.
REQ-034 WB bypass: rs1=5, rd1_d=0x11, we_w=1, rd_w=5, result_w=0xAA -> rd1_e_o=0xAA.
REQ-035 x0: rs2=0, rd2_d=0x55, we_w=1, rd_w=0, result_w=0x77 -> rd2_e_o=0.
REQ-036 Stall refresh: E holds rs1=7, rd1_e=0x1; stall with we_w=1, rd_w=7, result_w=0x99 -> rd1_e_o=0x99; all other fields unchanged; stall_cnt_o=1.
REQ-037 Flush with stall: flush_i=1 and stall_i=1 -> valid_e_o=0, ctrl_e_o=0, rd_e_o=0, bubble_cnt_o=1, stall_cnt_o unchanged.
REQ-038 Reset mid-stall: assert reset between edges -> all outputs 0 at once; after deassert, the next edge loads the D inputs.
